step_seq_driver: RTL
====================

// Module: step_seq_driver
// PURPOSE
//  Upstream driver for the 4-state start/step2/step3 sequencer FSM. Accepts one
//  command per valid/ready handshake and generates that FSM's start, step2 and
//  step3 inputs. Tracks progress via the FSM's 3-bit out code (001/010/100/111),
//  holds step3 for a programmable dwell and times out on a stalled FSM.
// PARAMETERS
//  DW       4    width of req_dwell (dwell cycles in FSM state3)
//  TIMEOUT  16   max cycles in any WAIT state before error (>=2)
// PORTS
//  clk        in   1   single clock, all flops rising-edge
//  clr_n      in   1   reset, asynchronous assert, active-low
//  req_valid  in   1   command valid
//  req_ready  out  1   command accepted when req_valid&&req_ready
//  req_go2    in   1   1: full sequence; 0: abort after state2
//  req_dwell  in   DW  cycles FSM stays in state3 before step3 pulse
//  fsm_out    in   3   downstream FSM out code (combinational from its state)
//  start      out  1   to FSM start
//  step2      out  1   to FSM step2 (level)
//  step3      out  1   to FSM step3 (1-cycle pulse)
//  busy       out  1   command in progress
//  done       out  1   1-cycle pulse, sequence ended normally
//  status     out  2   result of last command: 0 OK, 1 ABORTED, 2 TIMEOUT, 3 LOST
// BEHAVIOUR
//  Reset (clr_n=0): IDLE; start/step2/step3/busy/done=0; status=0; counters=0.
//  All outputs registered, except req_ready = (state==IDLE) && (fsm_out==001).
//  States: IDLE, START, W_S1, W_S2, W_S3, DWELL, STEP3, W_S0, DONE.
//  IDLE: on handshake latch go2/dwell, clear status -> START (busy=1 next cycle).
//  START: start=1 for exactly this cycle; step2=go2 from here until W_S2 exits.
//  W_S1: wait fsm_out==010 -> W_S2. W_S2: wait 100; then go2 ? W_S3 : W_S0
//    with status=ABORTED (FSM samples step2=0 and returns to state0).
//  W_S3: wait 111 -> DWELL, load counter=dwell; step2 drops to 0.
//  DWELL: decrement; at 0 -> STEP3 (dwell=0: STEP3 next cycle).
//  STEP3: step3=1 one cycle -> W_S0. W_S0: wait 001 -> DONE.
//  DONE: done=1 one cycle, busy=0 -> IDLE.
//  Latency with go2=1 and dwell=D, healthy FSM: start at T+1 after handshake,
//    step3 at T+5+D, done at T+7+D.
//  Timeout: per-WAIT counter reset on entry; after TIMEOUT cycles without the
//    expected code -> status=TIMEOUT, all drives 0, busy=0, IDLE (no done).
//  LOST: fsm_out==001 seen in W_S2, W_S3 or DWELL (downstream cleared) ->
//    status=LOST, drives 0, IDLE next cycle.
//  Any fsm_out code outside {001,010,100,111} counts as not-expected (timeout path).
//  req_valid ignored while busy; req_ready stays 0 until IDLE and FSM in 001.
//  clr_n asserted mid-sequence: immediate return to reset values; step2/step3
//    drop asynchronously.
//  Dwell counter is DW bits, no wrap: max dwell 2^DW-1.
// STRUCTURE
//  Shared package simple_pkg: out codes OUT_S0=3'b001, OUT_S1=3'b010,
//    OUT_S2=3'b100, OUT_S3=3'b111; driver state enum; status codes ST_OK..ST_LOST.
//  One sub-module seq_cycle_counter (load/decrement/zero flag), instantiated
//    twice: timeout counter and dwell counter.
//  Main FSM plus registered outputs in step_seq_driver.
// TESTING
//  Bench pairs DUT with behavioural model of the downstream FSM (active-high clr).
//  1 go2=1, dwell=3 -> start@T+1, step2 high T+1..T+3, step3@T+8, done@T+10, status=0.
//  2 go2=0 -> step2 0 throughout, FSM 001->010->100->001, done pulse, status=1.
//  3 dwell=0 -> step3 the cycle after fsm_out first shows 111.
//  4 model frozen at 010 -> after 16 cycles in W_S2, status=2, busy=0, no done.
//  5 downstream clr pulsed during DWELL -> status=3, IDLE; next req accepted.
//  6 clr_n low during W_S3 -> all outputs 0 same cycle; req_valid while busy ignored.

Source files
------------

// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - shared codes and types for the sequencer driver
package simple_pkg;

  localparam logic [2:0] OUT_S0 = 3'b001;
  localparam logic [2:0] OUT_S1 = 3'b010;
  localparam logic [2:0] OUT_S2 = 3'b100;
  localparam logic [2:0] OUT_S3 = 3'b111;

  typedef enum logic [3:0] {
    D_IDLE,
    D_START,
    D_W_S1,
    D_W_S2,
    D_W_S3,
    D_DWELL,
    D_STEP3,
    D_W_S0,
    D_DONE
  } drv_state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ABORTED = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_LOST    = 2'd3
  } status_e;

endpackage

// File: rtl/seq_cycle_counter.sv
// rtl/seq_cycle_counter.sv - loadable down counter with zero flag, saturating at 0
module seq_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/step_seq_driver.sv
// rtl/step_seq_driver.sv - command driver for the start/step2/step3 sequencer FSM
module step_seq_driver
  import simple_pkg::*;
#(
  parameter int DW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_go2,
  input  logic [DW-1:0] req_dwell,
  input  logic [2:0]    fsm_out,
  output logic          start,
  output logic          step2,
  output logic          step3,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);

  drv_state_e    state_q, state_d;
  status_e       status_q, status_d;
  logic          go2_q, go2_d;
  logic [DW-1:0] dwell_q, dwell_d, dwell_m1;
  logic          start_q, start_d, step2_q, step2_d, step3_q, step3_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          to_load, to_dec, to_zero;
  logic          dw_load, dw_dec, dw_zero;
  logic          expire, lost;

  assign dwell_m1 = dwell_q - 1'b1;

  // Wait counters are loaded with TIMEOUT-1 on entry so expiry lands on the TIMEOUT-th cycle.
  seq_cycle_counter #(.W(TW)) u_timeout (
    .clk_i      (clk),
    .rst_ni     (clr_n),
    .load_i     (to_load),
    .load_val_i (TO_LOAD),
    .dec_i      (to_dec),
    .zero_o     (to_zero)
  );

  seq_cycle_counter #(.W(DW)) u_dwell (
    .clk_i      (clk),
    .rst_ni     (clr_n),
    .load_i     (dw_load),
    .load_val_i (dwell_m1),
    .dec_i      (dw_dec),
    .zero_o     (dw_zero)
  );

  assign req_ready = (state_q == D_IDLE) && (fsm_out == OUT_S0);

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    go2_d    = go2_q;
    dwell_d  = dwell_q;
    start_d  = 1'b0;
    step2_d  = step2_q;
    step3_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    to_load  = 1'b0;
    to_dec   = 1'b0;
    dw_load  = 1'b0;
    dw_dec   = 1'b0;
    expire   = 1'b0;
    lost     = 1'b0;
    case (state_q)
      D_IDLE: begin
        if (req_valid && req_ready) begin
          go2_d    = req_go2;
          dwell_d  = req_dwell;
          status_d = ST_OK;
          start_d  = 1'b1;
          step2_d  = req_go2;
          busy_d   = 1'b1;
          state_d  = D_START;
        end
      end
      D_START: begin
        to_load = 1'b1;
        state_d = D_W_S1;
      end
      D_W_S1: begin
        if (fsm_out == OUT_S1) begin
          to_load = 1'b1;
          state_d = D_W_S2;
        end else if (to_zero) begin
          expire = 1'b1;
        end else begin
          to_dec = 1'b1;
        end
      end
      D_W_S2: begin
        if (fsm_out == OUT_S0) begin
          lost = 1'b1;
        end else if (fsm_out == OUT_S2) begin
          // The FSM samples step2 in state2 on this same edge, so step2 is released here.
          to_load = 1'b1;
          step2_d = 1'b0;
          if (go2_q) begin
            state_d = D_W_S3;
          end else begin
            status_d = ST_ABORTED;
            state_d  = D_W_S0;
          end
        end else if (to_zero) begin
          expire = 1'b1;
        end else begin
          to_dec = 1'b1;
        end
      end
      D_W_S3: begin
        if (fsm_out == OUT_S0) begin
          lost = 1'b1;
        end else if (fsm_out == OUT_S3) begin
          if (dwell_q == '0) begin
            step3_d = 1'b1;
            state_d = D_STEP3;
          end else begin
            dw_load = 1'b1;
            state_d = D_DWELL;
          end
        end else if (to_zero) begin
          expire = 1'b1;
        end else begin
          to_dec = 1'b1;
        end
      end
      D_DWELL: begin
        if (fsm_out == OUT_S0) begin
          lost = 1'b1;
        end else if (dw_zero) begin
          step3_d = 1'b1;
          state_d = D_STEP3;
        end else begin
          dw_dec = 1'b1;
        end
      end
      D_STEP3: begin
        to_load = 1'b1;
        state_d = D_W_S0;
      end
      D_W_S0: begin
        if (fsm_out == OUT_S0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = D_DONE;
        end else if (to_zero) begin
          expire = 1'b1;
        end else begin
          to_dec = 1'b1;
        end
      end
      D_DONE: begin
        state_d = D_IDLE;
      end
      default: begin
        state_d = D_IDLE;
      end
    endcase
    if (expire || lost) begin
      status_d = expire ? ST_TIMEOUT : ST_LOST;
      state_d  = D_IDLE;
      start_d  = 1'b0;
      step2_d  = 1'b0;
      step3_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= D_IDLE;
      status_q <= ST_OK;
      go2_q    <= 1'b0;
      dwell_q  <= '0;
      start_q  <= 1'b0;
      step2_q  <= 1'b0;
      step3_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      go2_q    <= go2_d;
      dwell_q  <= dwell_d;
      start_q  <= start_d;
      step2_q  <= step2_d;
      step3_q  <= step3_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign start  = start_q;
  assign step2  = step2_q;
  assign step3  = step3_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign status = status_q;

endmodule
